param_bus_mux: RTL

- N-source, parametrised-width priority bus multiplexer for the Mini SRC datapath bus.
- Provides a same-cycle combinational bus value and a registered copy, the index of the granted source, and a registered valid flag.
- Optional bus-hold mode: when no source drives, the bus keeps its last driven value instead of zero.
- Detects multi-driver conflicts (more than one `*_out` enable high) and records them in a sticky flag for control-unit debug.

---
 rtl/param_bus_mux.sv | 120 ++++++++++++
 1 files changed

// File: rtl/param_bus_mux.sv
// Priority bus multiplexer with registered copy, grant index and sticky conflict flag.
// Optional saturating conflict counter: define BUS_CONFLICT_CNT_EN.
module param_bus_mux #(
  parameter int WIDTH      = 32,
  parameter int NUM_SRC    = 8,
  parameter int HOLD_EMPTY = 0,
  parameter int CNT_W      = 8,
  localparam int IDX_W     = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_SRC*WIDTH-1:0] src_in,
  input  logic [NUM_SRC-1:0]       src_out,
  input  logic                     conflict_clr,
  output logic [WIDTH-1:0]         bus_comb,
  output logic [WIDTH-1:0]         bus_q,
  output logic                     bus_valid,
  output logic [IDX_W-1:0]         grant_idx,
`ifdef BUS_CONFLICT_CNT_EN
  output logic [CNT_W-1:0]         conflict_cnt,
`endif
  output logic                     conflict
);

  logic [IDX_W-1:0] w_gidx;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_hold;
  logic             w_any;
  logic             w_multi;

  logic [WIDTH-1:0] r_bus_q;
  logic             r_valid;
  logic [IDX_W-1:0] r_gidx;
  logic             r_conf;

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    w_gidx = '0;
    w_sel  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_out[i]) begin
        w_gidx = IDX_W'(i);
        w_sel  = src_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_any   = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_out[i]) begin
        w_multi = w_multi | w_any;
        w_any   = 1'b1;
      end
    end
  end

  generate
    if (HOLD_EMPTY != 0) begin : g_hold
      assign w_hold = clr ? '0 : r_bus_q;
    end else begin : g_zero
      assign w_hold = '0;
    end
  endgenerate

  assign bus_comb = w_any ? w_sel : w_hold;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_bus_q <= '0;
      r_valid <= 1'b0;
      r_gidx  <= '0;
    end else begin
      r_bus_q <= bus_comb;
      r_valid <= w_any;
      if (w_any) r_gidx <= w_gidx;
    end
  end

  // A new conflict beats a simultaneous clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_conf <= 1'b0;
    end else if (w_multi) begin
      r_conf <= 1'b1;
    end else if (conflict_clr) begin
      r_conf <= 1'b0;
    end
  end

`ifdef BUS_CONFLICT_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (w_multi) begin
      if (conflict_clr) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (conflict_clr) begin
      r_cnt <= '0;
    end
  end

  assign conflict_cnt = r_cnt;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

  assign bus_q     = r_bus_q;
  assign bus_valid = r_valid;
  assign grant_idx = r_gidx;
  assign conflict  = r_conf;

endmodule
